// File: rtl/shift_out_driver.sv
// Purpose : serialize the output-register word onto an external 74HC595-style chain (sclk/sdata/latch).
// Latency : transfer starts on the edge after a word change is seen in IDLE; busy lasts 2*CLK_DIV*DATA_WIDTH+CLK_DIV cycles.
// Backpressure: none upstream; changes during a transfer coalesce and the latest word is sent next.
module shift_out_driver #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CLK_DIV    = 4,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] RESET_PAT  = '0
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    // retransmit request; named force_i because "force" is a reserved word
    input  logic                  force_i,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  latch,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] sent
);

    localparam int CNTW = $clog2(DATA_WIDTH);
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DATA_WIDTH - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOW   = 2'd1,
        S_HIGH  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] sent_q, sent_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [DIVW-1:0]       div_q, div_d;
    logic                  pending_q, pending_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, sdata_d;
    logic                  latch_q, latch_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  div_last;

    assign div_last = (div_q == DIV_LAST);

    // State, datapath and registered outputs; reset drops any transfer without a latch pulse.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            sent_q    <= RESET_PAT;
            cnt_q     <= '0;
            div_q     <= '0;
            pending_q <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            sent_q    <= sent_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; pin values are derived from the next state so every output is a flop.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        sent_d    = sent_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        pending_d = pending_q | force_i;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q || (data_in != sent_q)) begin
                    // Starting clears pending even if force arrives now: force plus change is one transfer.
                    shift_d   = data_in;
                    sent_d    = data_in;
                    cnt_d     = CNT_LAST;
                    div_d     = '0;
                    pending_d = 1'b0;
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    div_d = '0;
                    if (cnt_q == '0) begin
                        state_d = S_LATCH;
                    end else begin
                        shift_d = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                                            : {1'b0, shift_q[DATA_WIDTH-1:1]};
                        cnt_d   = cnt_q - CNTW'(1);
                        state_d = S_LOW;
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            S_LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sclk_d  = (state_d == S_HIGH);
        latch_d = (state_d == S_LATCH);
        busy_d  = (state_d != S_IDLE);
        sdata_d = 1'b0;
        if ((state_d == S_LOW) || (state_d == S_HIGH)) begin
            sdata_d = MSB_FIRST ? shift_d[DATA_WIDTH-1] : shift_d[0];
        end
    end

    assign sclk  = sclk_q;
    assign sdata = sdata_q;
    assign latch = latch_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sent  = sent_q;

endmodule

// File: tb/tb_shift_out_driver.sv
// Bench for shift_out_driver: two instances (8-bit MSB-first div 2, 8-bit LSB-first div 1).
// Outputs are sampled 1 time unit after each rising edge; per-window statistics are compared.
// Stimulus is a linear sequence of directed steps with hand-computed expectations.
module tb_shift_out_driver;

    logic       clk;
    logic       reset;
    logic       rst1;
    logic [7:0] d0, d1;
    logic       f0, f1;

    logic       sclk0, sdata0, latch0, busy0, done0;
    logic       sclk1, sdata1, latch1, busy1, done1;
    logic [7:0] sent0, sent1;

    logic        sel;
    logic        o_sclk, o_sdata, o_latch, o_busy, o_done;
    logic [31:0] o_sent;

    int total = 0;
    int bad   = 0;

    int          idx, n_busy, n_latch, n_done, n_sclk, n_rise, n_brise, last_fall, gap;
    logic [31:0] rx;
    logic        p_sclk, p_busy;

    shift_out_driver #(
        .DATA_WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1), .RESET_PAT(8'h00)
    ) u0 (
        .clk_i(clk), .reset(reset), .data_in(d0), .force_i(f0),
        .sclk(sclk0), .sdata(sdata0), .latch(latch0), .busy(busy0),
        .done(done0), .sent(sent0)
    );

    shift_out_driver #(
        .DATA_WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0), .RESET_PAT(8'h00)
    ) u1 (
        .clk_i(clk), .reset(rst1), .data_in(d1), .force_i(f1),
        .sclk(sclk1), .sdata(sdata1), .latch(latch1), .busy(busy1),
        .done(done1), .sent(sent1)
    );

    assign o_sclk  = sel ? sclk1  : sclk0;
    assign o_sdata = sel ? sdata1 : sdata0;
    assign o_latch = sel ? latch1 : latch0;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_done  = sel ? done1  : done0;
    assign o_sent  = sel ? {24'h0, sent1} : {24'h0, sent0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        idx = 0; n_busy = 0; n_latch = 0; n_done = 0; n_sclk = 0;
        n_rise = 0; n_brise = 0; last_fall = -1; gap = -1; rx = '0;
        p_sclk = o_sclk; p_busy = o_busy;
    endtask

    // One clock: wait for the edge, then record the settled outputs.
    task automatic sample();
        @(posedge clk);
        #1;
        idx++;
        if (o_busy)  n_busy++;
        if (o_latch) n_latch++;
        if (o_done)  n_done++;
        if (o_sclk)  n_sclk++;
        if (o_sclk && !p_sclk) begin
            n_rise++;
            rx = {rx[30:0], o_sdata};
        end
        if (o_busy && !p_busy) begin
            n_brise++;
            if (last_fall >= 0) gap = idx - last_fall;
        end
        if (!o_busy && p_busy) last_fall = idx;
        p_sclk = o_sclk;
        p_busy = o_busy;
    endtask

    initial begin
        reset = 1'b1; rst1 = 1'b1; d0 = 8'hA5; d1 = 8'h80; f0 = 1'b0; f1 = 1'b0; sel = 1'b0;
        #1;
        clear_stats();
        repeat (3) sample();
        chk("rst_busy",  {31'b0, o_busy},  32'd0);
        chk("rst_sclk",  {31'b0, o_sclk},  32'd0);
        chk("rst_latch", {31'b0, o_latch}, 32'd0);
        chk("rst_done",  {31'b0, o_done},  32'd0);
        chk("rst_sdata", {31'b0, o_sdata}, 32'd0);
        chk("rst_sent",  o_sent,           32'h00);

        // Reset-release send of 0xA5
        reset = 1'b0;
        clear_stats();
        sample();
        chk("a5_first_busy",  {31'b0, o_busy},  32'd1);
        chk("a5_first_sdata", {31'b0, o_sdata}, 32'd1);
        chk("a5_first_sclk",  {31'b0, o_sclk},  32'd0);
        chk("a5_sent",        o_sent,           32'hA5);
        repeat (39) sample();
        chk("a5_bits",   rx,      32'hA5);
        chk("a5_rises",  n_rise,  32'd8);
        chk("a5_busy",   n_busy,  32'd34);
        chk("a5_latch",  n_latch, 32'd2);
        chk("a5_done",   n_done,  32'd1);
        chk("a5_starts", n_brise, 32'd1);

        // Quiescence with an unchanged word
        clear_stats();
        repeat (200) sample();
        chk("quiet_sclk",  n_sclk,  32'd0);
        chk("quiet_latch", n_latch, 32'd0);
        chk("quiet_busy",  n_busy,  32'd0);

        // Coalescing: 0x01 in flight, then 0x02 and 0x03 arrive
        d0 = 8'h01;
        clear_stats();
        sample();
        repeat (4) sample();
        d0 = 8'h02;
        repeat (5) sample();
        d0 = 8'h03;
        repeat (75) sample();
        chk("coal_starts", n_brise, 32'd2);
        chk("coal_bits",   rx,      32'h0103);
        chk("coal_gap",    gap,     32'd1);
        chk("coal_done",   n_done,  32'd2);
        chk("coal_latch",  n_latch, 32'd4);
        chk("coal_sent",   o_sent,  32'h03);

        // Force: first settle on 0x3C, then force while idle and again mid-transfer
        d0 = 8'h3C;
        repeat (40) sample();
        chk("pre_force_sent", o_sent, 32'h3C);
        clear_stats();
        f0 = 1'b1;
        sample();
        f0 = 1'b0;
        sample();
        chk("force_busy", {31'b0, o_busy}, 32'd1);
        repeat (8) sample();
        f0 = 1'b1;
        sample();
        f0 = 1'b0;
        repeat (100) sample();
        chk("force_starts", n_brise, 32'd2);
        chk("force_bits",   rx,      32'h3C3C);
        chk("force_done",   n_done,  32'd2);

        // Reset during bit 4 of a 0x5A transfer
        d0 = 8'h5A;
        clear_stats();
        repeat (18) sample();
        chk("mid_rises",  n_rise,  32'd4);
        chk("mid_latch",  n_latch, 32'd0);
        reset = 1'b1;
        sample();
        chk("mid_rst_sclk",  {31'b0, o_sclk},  32'd0);
        chk("mid_rst_latch", {31'b0, o_latch}, 32'd0);
        chk("mid_rst_busy",  {31'b0, o_busy},  32'd0);
        chk("mid_rst_sent",  o_sent,           32'h00);
        reset = 1'b0;
        clear_stats();
        repeat (40) sample();
        chk("retx_starts", n_brise, 32'd1);
        chk("retx_bits",   rx,      32'h5A);
        chk("retx_latch",  n_latch, 32'd2);
        chk("retx_done",   n_done,  32'd1);
        chk("retx_sent",   o_sent,  32'h5A);

        // LSB-first, divider 1, 0x80
        sel = 1'b1;
        #1;
        clear_stats();
        chk("u1_rst_busy", {31'b0, o_busy}, 32'd0);
        chk("u1_rst_sent", o_sent,          32'h00);
        rst1 = 1'b0;
        sample();
        chk("u1_first_busy",  {31'b0, o_busy},  32'd1);
        chk("u1_first_sdata", {31'b0, o_sdata}, 32'd0);
        repeat (24) sample();
        chk("u1_bits",  rx,      32'h01);
        chk("u1_rises", n_rise,  32'd8);
        chk("u1_sclk",  n_sclk,  32'd8);
        chk("u1_busy",  n_busy,  32'd17);
        chk("u1_latch", n_latch, 32'd1);
        chk("u1_done",  n_done,  32'd1);
        chk("u1_sent",  o_sent,  32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_out_driver.md
# shift_out_driver

Serializes the parallel word held by the wishbone output register onto an external daisy-chained serial-in/parallel-out shift register (74HC595-style: serial clock, serial data, storage latch). It sits directly downstream of the output register: its `data_in` is wired to that register's `out`. It retransmits automatically whenever the word changes, so software writes to the output register propagate to the external pins without further bus traffic.

## Interface
- `DATA_WIDTH`, 32: bits per word and external chain length; must be ≥ 2.
- `CLK_DIV`, 4: `clk_i` cycles per `sclk` half-period and per latch pulse; must be ≥ 1.
- `MSB_FIRST`, 1: 1 = bit `DATA_WIDTH-1` shifted first; 0 = bit 0 first.
- `RESET_PAT`, 0: value loaded into the sent-word shadow on reset.

Ports:
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  parallel word from the output register.
- `force`  in  1  single-cycle request to retransmit even if the word is unchanged.
- `sclk`  out  1  serial clock; external chain samples on its rising edge.
- `sdata`  out  1  serial data.
- `latch`  out  1  storage-register latch; active high.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `sent`  out  DATA_WIDTH  last word captured for transmission.

## Operation
- Registers:
  - `shift`: DATA_WIDTH bits.
  - `sent`: DATA_WIDTH bits.
  - bit counter: clog2(DATA_WIDTH) bits.
  - divider: clog2(CLK_DIV) bits, minimum 1.
  - `pending` flag.
  - FSM states: IDLE, LOW, HIGH, LATCH.
- Reset (any state, takes effect next edge):
  - State = IDLE; all outputs 0.
  - `sent` = RESET_PAT.
  - `pending` = 1, so the first idle cycle after reset always transmits.
  - A transfer interrupted by reset produces no latch pulse.
- `pending` is set by `force` in any state. It is cleared when a transfer starts.
- IDLE:
  - Start condition: `pending`, or `data_in != sent`.
  - On start: `shift`/`sent` ← `data_in`; bit counter ← DATA_WIDTH-1; divider ← 0; go to LOW; `busy` ← 1.
  - If no start condition: `sclk`, `sdata`, `latch` are held at 0.
- LOW:
  - `sclk` = 0; `sdata` = current bit (`shift` MSB if MSB_FIRST, else LSB).
  - After CLK_DIV cycles, go to HIGH.
- HIGH:
  - `sclk` = 1; `sdata` unchanged.
  - After CLK_DIV cycles:
    - If bit counter = 0, go to LATCH.
    - Otherwise shift `shift` one place toward the output end, decrement the counter, and go to LOW.
- LATCH:
  - `sclk` = 0, `sdata` = 0, `latch` = 1 for CLK_DIV cycles.
  - Then go to IDLE; `busy` ← 0; `done` pulses for one cycle.
- Changes to `data_in` during a transfer do not disturb it; the captured word is sent intact. On return to IDLE the comparison against `sent` triggers the next transfer.
- Multiple changes within one transfer coalesce: only the value present in the next IDLE cycle is sent.
- A `force` together with a data change causes exactly one transfer.

## Timing
- Start latency: `data_in` changes before edge N (IDLE) → edge N loads and enters LOW; `busy`=1 and the first `sdata` bit are valid after edge N.
- Transfer length: `busy` high for 2·CLK_DIV·DATA_WIDTH + CLK_DIV cycles.
- `done` is asserted in the first cycle after `busy` falls.
- `sdata` is stable for CLK_DIV cycles before and CLK_DIV cycles after each `sclk` rising edge.
- Back-to-back transfers: minimum one IDLE cycle between the end of LATCH and the next LOW.
- CLK_DIV=1: `sclk` toggles every cycle and the latch pulse is one cycle wide.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset-release send (DATA_WIDTH=8, CLK_DIV=2, MSB_FIRST=1, `data_in`=0xA5):
  - Expect bits 1,0,1,0,0,1,0,1 at successive `sclk` rises.
  - Expect `latch` high 2 cycles, `busy` high 34 cycles, a single `done`, and `sent`=0xA5.
- Quiescence: hold `data_in`=0xA5 for 200 cycles after `done` → `sclk`, `latch`, `busy` stay 0.
- Coalescing: during an 0x01 transfer, drive 0x02 then 0x03.
  - Expect 0x01 to complete, then exactly one further transfer of 0x03, with one IDLE cycle between them.
- Force: with the driver idle and `data_in`=`sent`=0x3C, pulse `force` for 1 cycle.
  - Expect one transfer of 0x3C starting the next edge.
  - A `force` pulsed mid-transfer yields exactly one extra transfer.
- Reset mid-transfer: assert `reset` during bit 4.
  - Next edge: `sclk`=`latch`=`busy`=0, and no latch pulse ever follows.
  - After release: a full retransfer of the current `data_in`.
- LSB-first, fastest divider (MSB_FIRST=0, CLK_DIV=1, `data_in`=0x80):
  - Expect seven 0 bits, then a 1 on the eighth rise.
  - Expect `busy` high for 17 cycles.
